// File: rtl/operator_slot_sequencer.sv
// operator_slot_sequencer
// Per-sample scheduler for the shared operator datapath. A sample tick starts a
// frame. The frame issues every (bank, op) slot once, in order, SLOT_SPACING
// clocks apart. It then waits for the datapath pipeline to empty. Key-on events
// from the register file are held in a pending bitmap. Each one is delivered as
// a single key_on_pulse on that operator's next issue.
module operator_slot_sequencer #(
    parameter int NUM_BANKS      = 2,
    parameter int OPS_PER_BANK   = 18,
    parameter int BANK_NUM_WIDTH = 1,
    parameter int OP_NUM_WIDTH   = 5,
    parameter int SLOT_SPACING   = 2,
    parameter int PIPELINE_DELAY = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sample_tick,
    input  logic                      kon_valid,
    input  logic [BANK_NUM_WIDTH-1:0] kon_bank,
    input  logic [OP_NUM_WIDTH-1:0]   kon_op,
    output logic                      sample_clk_en,
    output logic [BANK_NUM_WIDTH-1:0] bank_num,
    output logic [OP_NUM_WIDTH-1:0]   op_num,
    output logic                      key_on_pulse,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);

    localparam int NUM_SLOTS = NUM_BANKS * OPS_PER_BANK;
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Spacing of one means slots go out on consecutive clocks with no GAP state.
    localparam bit BACK_TO_BACK = (SLOT_SPACING == 1);

    // Terminal counts. GAP_LAST is unused when BACK_TO_BACK is set.
    localparam logic [3:0] GAP_LAST   = 4'(SLOT_SPACING - 2);
    localparam logic [7:0] DRAIN_LAST = 8'(PIPELINE_DELAY - 1);

    localparam logic [BANK_NUM_WIDTH-1:0] LAST_BANK = BANK_NUM_WIDTH'(NUM_BANKS - 1);
    localparam logic [OP_NUM_WIDTH-1:0]   LAST_OP   = OP_NUM_WIDTH'(OPS_PER_BANK - 1);

    logic [1:0]                state;
    logic [3:0]                gap_cnt;
    logic [7:0]                drain_cnt;
    logic [NUM_SLOTS-1:0]      pending;

    logic                      issue;
    logic                      last_slot;
    logic                      kon_ok;
    logic [SLOT_W-1:0]         cur_idx;
    logic [SLOT_W-1:0]         kon_idx;
    logic [BANK_NUM_WIDTH-1:0] nxt_bank;
    logic [OP_NUM_WIDTH-1:0]   nxt_op;
    logic [NUM_SLOTS-1:0]      set_vec;
    logic [NUM_SLOTS-1:0]      clr_vec;

    // Flat bitmap position of a (bank, op) pair: bank-major, matching issue order.
    function automatic logic [SLOT_W-1:0] slot_index(
        input logic [BANK_NUM_WIDTH-1:0] b,
        input logic [OP_NUM_WIDTH-1:0]   o
    );
        return SLOT_W'(int'(b) * OPS_PER_BANK + int'(o));
    endfunction

    // Decode the current slot and the incoming key-on event, and step to the next slot.
    always_comb begin
        issue     = (state == ST_ISSUE);
        last_slot = (bank_num == LAST_BANK) && (op_num == LAST_OP);
        cur_idx   = slot_index(bank_num, op_num);
        kon_idx   = slot_index(kon_bank, kon_op);
        // Events that name a slot outside the array are dropped.
        kon_ok    = kon_valid && (int'(kon_bank) < NUM_BANKS) && (int'(kon_op) < OPS_PER_BANK);
        if (op_num == LAST_OP) begin
            nxt_op   = '0;
            nxt_bank = bank_num + BANK_NUM_WIDTH'(1);
        end else begin
            nxt_op   = op_num + OP_NUM_WIDTH'(1);
            nxt_bank = bank_num;
        end
    end

    // Build the pending-bitmap set/clear masks. A clear on the slot being issued beats a same-cycle set.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (kon_ok) begin
            set_vec[kon_idx] = 1'b1;
        end
        if (issue) begin
            clr_vec[cur_idx] = 1'b1;
        end
    end

    // Derive the strobes from the state. A key-on arriving in its own issue cycle goes out with this pulse.
    always_comb begin
        sample_clk_en = issue;
        busy          = (state != ST_IDLE);
        frame_done    = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
        key_on_pulse  = issue && (pending[cur_idx] || (kon_ok && (kon_idx == cur_idx)));
    end

    // Frame sequencer: step through IDLE, ISSUE/GAP per slot, then DRAIN. Slot registers load on entry to ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            drain_cnt <= '0;
            bank_num  <= '0;
            op_num    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        state    <= ST_ISSUE;
                        bank_num <= '0;
                        op_num   <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (last_slot) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end else if (BACK_TO_BACK) begin
                        state    <= ST_ISSUE;
                        bank_num <= nxt_bank;
                        op_num   <= nxt_op;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= ST_ISSUE;
                        bank_num <= nxt_bank;
                        op_num   <= nxt_op;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // Record a tick that arrives while a frame is in progress, including its frame_done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= sample_tick && busy;
        end
    end

    // Pending key-on bitmap. Repeated events before the issue collapse into one bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_vec) & ~clr_vec;
        end
    end

endmodule

// File: tb/tb_operator_slot_sequencer.sv
// tb_operator_slot_sequencer
// Runs two sequencers from the same stimulus, one with slot spacing 2 and one
// with spacing 1. Each cycle, every output is compared with a frame-timing
// reference model. The model derives each slot from the tick cycle by
// arithmetic, and keeps the pending key-ons in a plain bit array.
module tb_operator_slot_sequencer;

    localparam int NB  = 2;
    localparam int OPB = 18;
    localparam int NS  = NB * OPB;
    localparam int PD  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       sample_tick;
    logic       kon_valid;
    logic [0:0] kon_bank;
    logic [4:0] kon_op;

    logic       dut_sce  [2];
    logic [0:0] dut_bank [2];
    logic [4:0] dut_op   [2];
    logic       dut_kp   [2];
    logic       dut_busy [2];
    logic       dut_fd   [2];
    logic       dut_ovr  [2];

    operator_slot_sequencer #(.SLOT_SPACING(2), .PIPELINE_DELAY(PD)) u_s2 (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
        .kon_valid(kon_valid), .kon_bank(kon_bank), .kon_op(kon_op),
        .sample_clk_en(dut_sce[0]), .bank_num(dut_bank[0]), .op_num(dut_op[0]),
        .key_on_pulse(dut_kp[0]), .busy(dut_busy[0]), .frame_done(dut_fd[0]),
        .overrun(dut_ovr[0])
    );

    operator_slot_sequencer #(.SLOT_SPACING(1), .PIPELINE_DELAY(PD)) u_s1 (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
        .kon_valid(kon_valid), .kon_bank(kon_bank), .kon_op(kon_op),
        .sample_clk_en(dut_sce[1]), .bank_num(dut_bank[1]), .op_num(dut_op[1]),
        .key_on_pulse(dut_kp[1]), .busy(dut_busy[1]), .frame_done(dut_fd[1]),
        .overrun(dut_ovr[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state, one entry per instance.
    int t0      [2];
    bit started [2];
    bit pend    [2][NS];
    int last_k  [2];
    bit ovr_q   [2];

    function automatic int spacing_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_check(input int i);
        int s, rel, k, kk, last_rel, done_rel;
        bit iss, bsy, fd, kp, kon_ok;
        s        = spacing_of(i);
        last_rel = 1 + (NS - 1) * s;
        done_rel = last_rel + PD;
        if (!reset_n) begin
            check($sformatf("rst_i%0d_c%0d_sce", i, cyc),  32'(dut_sce[i]),  32'd0);
            check($sformatf("rst_i%0d_c%0d_bank", i, cyc), 32'(dut_bank[i]), 32'd0);
            check($sformatf("rst_i%0d_c%0d_op", i, cyc),   32'(dut_op[i]),   32'd0);
            check($sformatf("rst_i%0d_c%0d_kp", i, cyc),   32'(dut_kp[i]),   32'd0);
            check($sformatf("rst_i%0d_c%0d_busy", i, cyc), 32'(dut_busy[i]), 32'd0);
            check($sformatf("rst_i%0d_c%0d_fd", i, cyc),   32'(dut_fd[i]),   32'd0);
            check($sformatf("rst_i%0d_c%0d_ovr", i, cyc),  32'(dut_ovr[i]),  32'd0);
            started[i] = 1'b0;
            last_k[i]  = 0;
            ovr_q[i]   = 1'b0;
            for (int j = 0; j < NS; j++) pend[i][j] = 1'b0;
            return;
        end
        rel    = cyc - t0[i];
        bsy    = started[i] && (rel >= 1) && (rel <= done_rel);
        iss    = bsy && (rel <= last_rel) && (((rel - 1) % s) == 0);
        k      = iss ? (rel - 1) / s : last_k[i];
        kon_ok = kon_valid && (int'(kon_bank) < NB) && (int'(kon_op) < OPB);
        kk     = int'(kon_bank) * OPB + int'(kon_op);
        kp     = iss && (pend[i][k] || (kon_ok && kk == k));
        fd     = bsy && (rel == done_rel);

        check($sformatf("i%0d_c%0d_sce", i, cyc),  32'(dut_sce[i]),  32'(iss));
        check($sformatf("i%0d_c%0d_bank", i, cyc), 32'(dut_bank[i]), 32'(k / OPB));
        check($sformatf("i%0d_c%0d_op", i, cyc),   32'(dut_op[i]),   32'(k % OPB));
        check($sformatf("i%0d_c%0d_kp", i, cyc),   32'(dut_kp[i]),   32'(kp));
        check($sformatf("i%0d_c%0d_busy", i, cyc), 32'(dut_busy[i]), 32'(bsy));
        check($sformatf("i%0d_c%0d_fd", i, cyc),   32'(dut_fd[i]),   32'(fd));
        check($sformatf("i%0d_c%0d_ovr", i, cyc),  32'(dut_ovr[i]),  32'(ovr_q[i]));

        // Advance the model to the next cycle.
        if (kon_ok) pend[i][kk] = 1'b1;
        if (iss)    pend[i][k]  = 1'b0;
        last_k[i] = k;
        ovr_q[i]  = sample_tick && bsy;
        if (sample_tick && !bsy) begin
            started[i] = 1'b1;
            t0[i]      = cyc;
        end
    endtask

    // One clock: check at the falling edge, then move past the next rising edge and drop one-shot inputs.
    task automatic step();
        @(negedge clk);
        model_check(0);
        model_check(1);
        @(posedge clk);
        #1;
        cyc++;
        sample_tick = 1'b0;
        kon_valid   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic kon(input int b, input int o);
        kon_valid = 1'b1;
        kon_bank  = 1'(b);
        kon_op    = 5'(o);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
    endtask

    initial begin
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        kon_valid   = 1'b0;
        kon_bank    = '0;
        kon_op      = '0;
        for (int i = 0; i < 2; i++) begin
            t0[i] = 0; started[i] = 1'b0; last_k[i] = 0; ovr_q[i] = 1'b0;
            for (int j = 0; j < NS; j++) pend[i][j] = 1'b0;
        end
        #1;
        run(2);
        reset_n = 1'b1;
        run(2);

        // Plain frame: full slot order, drain and busy release.
        tick();
        run(80);

        // Key-on for (1,5) before the tick, then a frame with no pending key-on.
        kon(1, 5);
        step();
        tick();
        run(80);
        tick();
        run(80);

        // Tick at T+10 while busy is dropped and reported as overrun.
        tick();
        run(9);
        sample_tick = 1'b1;
        step();
        run(75);

        // Key-on for (0,3) in its own issue cycle, then a follow-up frame.
        tick();
        run(6);
        kon(0, 3);
        step();
        run(75);
        tick();
        run(80);

        // Out-of-range key-on, then reset in the middle of a frame, then a restart.
        kon(0, 20);
        step();
        kon(1, 31);
        step();
        tick();
        run(29);
        reset_n = 1'b0;
        run(2);
        reset_n = 1'b1;
        tick();
        run(80);

        // Random ticks, key-ons and an occasional reset.
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 29) == 0) sample_tick = 1'b1;
            if ($urandom_range(0, 3) == 0) kon(int'($urandom_range(0, 1)), int'($urandom_range(0, 21)));
            if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
            step();
            reset_n = 1'b1;
        end
        run(90);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
